// File: rtl/aes_job_sched.sv
// Round-robin scheduler that shares one word-serial AES accelerator among NUM_REQ requesters.
// Only one job is in flight at a time: fill, issue, wait, fetch, acknowledge, then return the result.
module aes_job_sched #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_v_i,
  input  logic [NUM_REQ*128-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]     req_op_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     resp_v_o,
  output logic [127:0]           resp_data_o,
  input  logic [NUM_REQ-1:0]     resp_yumi_i,
  output logic [15:0]            accel_data_o,
  output logic [2:0]             accel_fill_addr_o,
  output logic                   accel_data_w_o,
  output logic                   accel_issue_o,
  output logic                   accel_opcode_o,
  output logic [2:0]             accel_fetch_addr_o,
  output logic                   accel_result_yumi_o,
  input  logic [15:0]            accel_data_i,
  input  logic                   accel_data_v_i,
  input  logic                   accel_ready_i,
  output logic                   busy_o
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FETCH = 3'd4,
    S_ACK   = 3'd5,
    S_RESP  = 3'd6
  } state_e;

  state_e          state_q;
  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] owner_q;
  logic [2:0]      k_q;
  logic [127:0]    block_q;
  logic [127:0]    result_q;
  logic            op_q;

  logic [ID_W-1:0] grant_s;
  logic [ID_W-1:0] cand_s;
  logic            found_s;

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_s = '0;
    cand_s  = '0;
    found_s = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand_s = ID_W'((int'(rr_q) + 1 + j) % NUM_REQ);
      if (!found_s && req_v_i[cand_s]) begin
        found_s = 1'b1;
        grant_s = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Scheduler state machine and job/result storage.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      rr_q     <= ID_W'(NUM_REQ - 1);
      owner_q  <= '0;
      k_q      <= 3'd0;
      block_q  <= 128'd0;
      result_q <= 128'd0;
      op_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_s) begin
            block_q <= req_data_i[int'(grant_s)*128 +: 128];
            op_q    <= req_op_i[grant_s];
            owner_q <= grant_s;
            rr_q    <= grant_s;
            k_q     <= 3'd0;
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          k_q <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accel_ready_i) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (accel_data_v_i) begin
            k_q     <= 3'd0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          result_q[{k_q, 4'b0000} +: 16] <= accel_data_i;
          k_q <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (resp_yumi_i[owner_q]) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state; ready is additionally masked while reset is held.
  always_comb begin
    req_ready_o         = '0;
    resp_v_o            = '0;
    resp_data_o         = result_q;
    accel_data_o        = 16'd0;
    accel_fill_addr_o   = 3'd0;
    accel_data_w_o      = 1'b0;
    accel_issue_o       = 1'b0;
    accel_opcode_o      = 1'b0;
    accel_fetch_addr_o  = 3'd0;
    accel_result_yumi_o = 1'b0;
    busy_o              = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (found_s && !reset_i) begin
          req_ready_o[grant_s] = 1'b1;
        end else begin
          req_ready_o = '0;
        end
      end
      S_FILL: begin
        accel_data_w_o    = 1'b1;
        accel_fill_addr_o = k_q;
        accel_data_o      = block_q[{k_q, 4'b0000} +: 16];
      end
      S_ISSUE: begin
        accel_issue_o  = accel_ready_i;
        accel_opcode_o = op_q;
      end
      S_WAIT: begin
        accel_opcode_o = op_q;
      end
      S_FETCH: begin
        accel_opcode_o     = op_q;
        accel_fetch_addr_o = k_q;
      end
      S_ACK: begin
        accel_opcode_o      = op_q;
        accel_result_yumi_o = 1'b1;
      end
      S_RESP: begin
        resp_v_o[owner_q] = 1'b1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_job_sched.sv
// Directed bench for aes_job_sched: 2-, 4- and 1-requester builds, each driving a small accelerator model.
// Model result: ~block for opcode 0, block ^ 0x5A5A per word for opcode 1, valid 10 cycles after issue.
module tb_aes_job_sched;

  localparam logic [127:0] BLK0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] BLK1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] MASK = {8{16'h5A5A}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hold_nr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Accelerator interfaces: index 0 = NUM_REQ 2, 1 = NUM_REQ 4, 2 = NUM_REQ 1
  logic        a_w [3], a_iss [3], a_op [3], a_ry [3], a_v [3], a_rdy [3], iss_op [3];
  logic [15:0] a_do [3], a_di [3];
  logic [2:0]  a_fa [3], a_ka [3];
  logic [15:0] mem [3][8];
  logic [15:0] res [3][8];
  int          cnt [3], nwr [3], niss [3], nry [3], seqerr [3];

  logic [1:0]   rv0 = '0, rop0 = '0, ry0 = '0, rrdy0, rsv0;
  logic [255:0] rd0 = '0;
  logic [127:0] rsd0;
  logic         busy0;
  logic [3:0]   rv4 = '0, rop4 = '0, ry4 = '0, rrdy4, rsv4;
  logic [511:0] rd4 = '0;
  logic [127:0] rsd4;
  logic         busy4;
  logic         rv1 = 1'b0, rop1 = 1'b0, ry1 = 1'b0, rrdy1, rsv1, busy1;
  logic [127:0] rd1 = '0;
  logic [127:0] rsd1;

  aes_job_sched #(.NUM_REQ(2)) dut (
    .clk_i(clk), .reset_i(rst), .req_v_i(rv0), .req_data_i(rd0), .req_op_i(rop0),
    .req_ready_o(rrdy0), .resp_v_o(rsv0), .resp_data_o(rsd0), .resp_yumi_i(ry0),
    .accel_data_o(a_do[0]), .accel_fill_addr_o(a_fa[0]), .accel_data_w_o(a_w[0]),
    .accel_issue_o(a_iss[0]), .accel_opcode_o(a_op[0]), .accel_fetch_addr_o(a_ka[0]),
    .accel_result_yumi_o(a_ry[0]), .accel_data_i(a_di[0]), .accel_data_v_i(a_v[0]),
    .accel_ready_i(a_rdy[0] & ~hold_nr), .busy_o(busy0));

  aes_job_sched #(.NUM_REQ(4)) dut4 (
    .clk_i(clk), .reset_i(rst), .req_v_i(rv4), .req_data_i(rd4), .req_op_i(rop4),
    .req_ready_o(rrdy4), .resp_v_o(rsv4), .resp_data_o(rsd4), .resp_yumi_i(ry4),
    .accel_data_o(a_do[1]), .accel_fill_addr_o(a_fa[1]), .accel_data_w_o(a_w[1]),
    .accel_issue_o(a_iss[1]), .accel_opcode_o(a_op[1]), .accel_fetch_addr_o(a_ka[1]),
    .accel_result_yumi_o(a_ry[1]), .accel_data_i(a_di[1]), .accel_data_v_i(a_v[1]),
    .accel_ready_i(a_rdy[1]), .busy_o(busy4));

  aes_job_sched #(.NUM_REQ(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .req_v_i(rv1), .req_data_i(rd1), .req_op_i(rop1),
    .req_ready_o(rrdy1), .resp_v_o(rsv1), .resp_data_o(rsd1), .resp_yumi_i(ry1),
    .accel_data_o(a_do[2]), .accel_fill_addr_o(a_fa[2]), .accel_data_w_o(a_w[2]),
    .accel_issue_o(a_iss[2]), .accel_opcode_o(a_op[2]), .accel_fetch_addr_o(a_ka[2]),
    .accel_result_yumi_o(a_ry[2]), .accel_data_i(a_di[2]), .accel_data_v_i(a_v[2]),
    .accel_ready_i(a_rdy[2]), .busy_o(busy1));

  assign a_di[0] = res[0][a_ka[0]];
  assign a_di[1] = res[1][a_ka[1]];
  assign a_di[2] = res[2][a_ka[2]];

  // Accelerator model: not ready for one cycle after reset, result valid 10 cycles after issue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 3; u++) begin
        a_v[u]   <= 1'b0;
        a_rdy[u] <= 1'b0;
        cnt[u]   <= 0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        a_rdy[u] <= 1'b1;
        if (a_w[u]) begin
          mem[u][a_fa[u]] <= a_do[u];
          if (a_fa[u] != 3'(nwr[u] % 8)) seqerr[u] <= seqerr[u] + 1;
          nwr[u] <= nwr[u] + 1;
        end
        if (a_iss[u]) begin
          cnt[u]    <= 10;
          niss[u]   <= niss[u] + 1;
          iss_op[u] <= a_op[u];
        end else if (cnt[u] > 0) begin
          cnt[u] <= cnt[u] - 1;
          if (cnt[u] == 1) begin
            a_v[u] <= 1'b1;
            for (int k = 0; k < 8; k++)
              res[u][k] <= iss_op[u] ? (mem[u][k] ^ 16'h5A5A) : ~mem[u][k];
          end
        end
        if (a_ry[u]) begin
          a_v[u] <= 1'b0;
          nry[u] <= nry[u] + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (rrdy0 !== 2'b00 || rsv0 !== 2'b00 || busy0 !== 1'b0 || rsd0 !== 128'd0) begin
      errors++;
      $display("FAIL reset_req_side got rdy=%b v=%b busy=%b data=%h exp 0", rrdy0, rsv0, busy0, rsd0);
    end
    checks++;
    if (a_w[0] !== 1'b0 || a_iss[0] !== 1'b0 || a_op[0] !== 1'b0 || a_ry[0] !== 1'b0 ||
        a_do[0] !== 16'd0 || a_fa[0] !== 3'd0 || a_ka[0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_accel_side got w=%b iss=%b op=%b ry=%b d=%h fa=%0d ka=%0d exp 0",
               a_w[0], a_iss[0], a_op[0], a_ry[0], a_do[0], a_fa[0], a_ka[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int w0, i0, y0, s0, n, bad;
    w0 = nwr[0]; i0 = niss[0]; y0 = nry[0]; s0 = seqerr[0];
    rd0[127:0] = BLK0; rop0 = 2'b00; rv0 = 2'b01;
    #1;
    checks++;
    if (rrdy0 !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", rrdy0); end
    tick();
    rv0 = 2'b00;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy0); end
    for (n = 0; n < 100 && rsv0 === 2'b00; n++) tick();
    checks++;
    if (rsv0 !== 2'b01) begin errors++; $display("FAIL single_resp_v got %b exp 01", rsv0); end
    checks++;
    if (rsd0 !== ~BLK0) begin errors++; $display("FAIL single_data got %h exp %h", rsd0, ~BLK0); end
    bad = 0;
    for (int k = 0; k < 8; k++) if (mem[0][k] !== 16'(k)) bad++;
    checks++;
    if (nwr[0] - w0 != 8 || seqerr[0] != s0 || bad != 0) begin
      errors++;
      $display("FAIL single_fill got writes=%0d seqerr=%0d badwords=%0d exp 8 0 0", nwr[0] - w0, seqerr[0] - s0, bad);
    end
    checks++;
    if (niss[0] - i0 != 1 || iss_op[0] !== 1'b0 || nry[0] - y0 != 1) begin
      errors++;
      $display("FAIL single_strobes got issues=%0d op=%b yumis=%0d exp 1 0 1", niss[0] - i0, iss_op[0], nry[0] - y0);
    end
    rv0 = 2'b11;
    #1;
    checks++;
    if (rrdy0 !== 2'b00) begin errors++; $display("FAIL single_ready_in_resp got %b exp 00", rrdy0); end
    rv0 = 2'b00;
    ry0 = 2'b01;
    tick();
    ry0 = 2'b00;
    checks++;
    if (rsv0 !== 2'b00 || busy0 !== 1'b0 || rsd0 !== ~BLK0) begin
      errors++;
      $display("FAIL single_after_yumi got v=%b busy=%b data=%h exp 00 0 %h", rsv0, busy0, rsd0, ~BLK0);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]   exp_g [4];
    logic [127:0] exp_d;
    int n;
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    rd0 = {BLK1, BLK0}; rop0 = 2'b10; rv0 = 2'b11;
    for (int j = 0; j < 4; j++) begin
      #1;
      for (n = 0; n < 50 && rrdy0 === 2'b00; n++) tick();
      checks++;
      if (rrdy0 !== exp_g[j]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", j, rrdy0, exp_g[j]); end
      tick();
      for (n = 0; n < 100 && rsv0 === 2'b00; n++) tick();
      exp_d = exp_g[j][1] ? (BLK1 ^ MASK) : ~BLK0;
      checks++;
      if (rsv0 !== exp_g[j] || rsd0 !== exp_d) begin
        errors++;
        $display("FAIL rr_resp%0d got v=%b d=%h exp %b %h", j, rsv0, rsd0, exp_g[j], exp_d);
      end
      checks++;
      if (iss_op[0] !== exp_g[j][1]) begin errors++; $display("FAIL rr_opcode%0d got %b exp %b", j, iss_op[0], exp_g[j][1]); end
      ry0 = rsv0;
      tick();
      ry0 = 2'b00;
    end
    rv0 = 2'b00; rop0 = 2'b00;
  endtask

  task automatic test_issue_gate();
    int w0, i0, n;
    w0 = nwr[0]; i0 = niss[0];
    hold_nr = 1'b1;
    rv0 = 2'b01;
    #1;
    tick();
    rv0 = 2'b00;
    for (n = 0; n < 30 && nwr[0] - w0 < 8; n++) tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (a_iss[0] !== 1'b0 || niss[0] != i0) begin
        errors++;
        $display("FAIL gate_no_issue%0d got iss=%b count=%0d exp 0 0", c, a_iss[0], niss[0] - i0);
      end
      tick();
    end
    hold_nr = 1'b0;
    #1;
    checks++;
    if (a_iss[0] !== 1'b1) begin errors++; $display("FAIL gate_issue_on_ready got %b exp 1", a_iss[0]); end
    tick();
    checks++;
    if (a_iss[0] !== 1'b0 || niss[0] - i0 != 1) begin
      errors++;
      $display("FAIL gate_single_pulse got iss=%b count=%0d exp 0 1", a_iss[0], niss[0] - i0);
    end
    for (n = 0; n < 100 && rsv0 === 2'b00; n++) tick();
    checks++;
    if (rsv0 !== 2'b01 || rsd0 !== ~BLK0) begin errors++; $display("FAIL gate_resp got v=%b d=%h exp 01 %h", rsv0, rsd0, ~BLK0); end
    ry0 = 2'b01;
    tick();
    ry0 = 2'b00;
  endtask

  task automatic test_backpressure();
    int n;
    rop0 = 2'b10; rv0 = 2'b10;
    #1;
    checks++;
    if (rrdy0 !== 2'b10) begin errors++; $display("FAIL bp_grant got %b exp 10", rrdy0); end
    tick();
    rv0 = 2'b00;
    for (n = 0; n < 100 && rsv0 === 2'b00; n++) tick();
    for (int c = 0; c < 20; c++) begin
      ry0 = 2'b01; rv0 = 2'b01;
      #1;
      checks++;
      if (rsv0 !== 2'b10 || rsd0 !== (BLK1 ^ MASK) || rrdy0 !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b exp 10 %h 00", c, rsv0, rsd0, rrdy0, BLK1 ^ MASK);
      end
      tick();
    end
    rv0 = 2'b00; ry0 = 2'b10;
    tick();
    ry0 = 2'b00; rop0 = 2'b00;
    checks++;
    if (rsv0 !== 2'b00 || busy0 !== 1'b0) begin errors++; $display("FAIL bp_release got v=%b busy=%b exp 00 0", rsv0, busy0); end
  endtask

  task automatic test_reset_mid();
    int i0, n;
    i0 = niss[0];
    rd0 = {BLK1, BLK0}; rv0 = 2'b01;
    #1;
    tick();
    rv0 = 2'b00;
    for (n = 0; n < 50 && niss[0] == i0; n++) tick();
    tick();
    rv0 = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy0 !== 1'b0 || rsv0 !== 2'b00 || rrdy0 !== 2'b00 || a_op[0] !== 1'b0 || a_ry[0] !== 1'b0 ||
        a_w[0] !== 1'b0 || a_iss[0] !== 1'b0 || a_ka[0] !== 3'd0 || rsd0 !== 128'd0) begin
      errors++;
      $display("FAIL midreset_outputs got busy=%b v=%b rdy=%b op=%b ry=%b w=%b iss=%b ka=%0d d=%h exp all 0",
               busy0, rsv0, rrdy0, a_op[0], a_ry[0], a_w[0], a_iss[0], a_ka[0], rsd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (rrdy0 !== 2'b01) begin errors++; $display("FAIL midreset_first_grant got %b exp 01", rrdy0); end
    tick();
    rv0 = 2'b00;
    for (n = 0; n < 100 && rsv0 === 2'b00; n++) tick();
    checks++;
    if (rsv0 !== 2'b01 || rsd0 !== ~BLK0) begin errors++; $display("FAIL midreset_job got v=%b d=%h exp 01 %h", rsv0, rsd0, ~BLK0); end
    ry0 = 2'b01;
    tick();
    ry0 = 2'b00;
  endtask

  task automatic test_four_req();
    logic [127:0] exp_d;
    int n;
    for (int i = 0; i < 4; i++) rd4[i*128 +: 128] = {8{16'hA000 + 16'(i)}};
    rv4 = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      #1;
      for (n = 0; n < 50 && rrdy4 === 4'b0000; n++) tick();
      checks++;
      if (rrdy4 !== 4'(1 << j)) begin errors++; $display("FAIL n4_grant%0d got %b exp %b", j, rrdy4, 4'(1 << j)); end
      tick();
      for (n = 0; n < 100 && rsv4 === 4'b0000; n++) tick();
      exp_d = ~{8{16'hA000 + 16'(j)}};
      checks++;
      if (rsv4 !== 4'(1 << j) || rsd4 !== exp_d) begin
        errors++;
        $display("FAIL n4_resp%0d got v=%b d=%h exp %b %h", j, rsv4, rsd4, 4'(1 << j), exp_d);
      end
      ry4 = rsv4;
      tick();
      ry4 = 4'b0000;
    end
    rv4 = 4'b0000;
  endtask

  task automatic test_one_req();
    int n;
    rd1 = BLK1; rv1 = 1'b1;
    for (int j = 0; j < 2; j++) begin
      #1;
      for (n = 0; n < 50 && rrdy1 === 1'b0; n++) tick();
      checks++;
      if (rrdy1 !== 1'b1) begin errors++; $display("FAIL n1_grant%0d got %b exp 1", j, rrdy1); end
      tick();
      for (n = 0; n < 100 && rsv1 === 1'b0; n++) tick();
      checks++;
      if (rsv1 !== 1'b1 || rsd1 !== ~BLK1) begin errors++; $display("FAIL n1_resp%0d got v=%b d=%h exp 1 %h", j, rsv1, rsd1, ~BLK1); end
      ry1 = 1'b1;
      tick();
      ry1 = 1'b0;
    end
    rv1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_issue_gate();
    test_backpressure();
    test_reset_mid();
    test_four_req();
    test_one_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
